// File: rtl/keypad_entry.sv
// Keypad digit collector: assembles hex keys into a DIGITS-wide passcode and strobes it to the lock.
// Optional backspace key (input key_back) is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_entry #(
  parameter int DIGITS         = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10,
  localparam int CODE_W        = 4 * DIGITS,
  localparam int DCNT_W        = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              key_enter,
  input  logic              key_clear,
`ifdef KEYPAD_BACKSPACE_EN
  input  logic              key_back,
`endif
  input  logic [1:0]        user_sel,
  output logic [CODE_W-1:0] pass_out,
  output logic [1:0]        user_out,
  output logic              enter_out,
  output logic [DCNT_W-1:0] digit_cnt,
  output logic              entry_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, COMMIT} state_t;

  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DCNT_W-1:0] CNT_LAST  = DCNT_W'(DIGITS - 1);
  localparam logic [DCNT_W-1:0] CNT_ONE   = DCNT_W'(1);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   pass_q, pass_d;
  logic [1:0]          user_q, user_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                enter_q, enter_d;
  logic                back_w;

`ifdef KEYPAD_BACKSPACE_EN
  assign back_w = key_back;
`else
  assign back_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    user_d  = user_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;

    if (state_q == COMMIT) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else if (key_clear) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else if (key_enter) begin
      tmo_d = '0;
      if (state_q == FULL) begin
        pass_d  = shift_q;
        user_d  = user_sel;
        state_d = COMMIT;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (back_w) begin
      tmo_d = '0;
      if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        shift_d = shift_q >> 4;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? IDLE : COLLECT;
      end
    end else if (key_valid) begin
      tmo_d = '0;
      if (state_q == FULL) begin
        err_d = 1'b1;
      end else begin
        shift_d = {shift_q[CODE_W-5:0], key_code};
        cnt_d   = cnt_q + CNT_ONE;
        state_d = (cnt_q == CNT_LAST) ? FULL : COLLECT;
      end
    end else if (state_q == COLLECT || state_q == FULL) begin
      // Abandoned partial entry: discard once the idle count reaches TIMEOUT_CYCLES.
      if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end else begin
      tmo_d = '0;
    end

    busy_d  = (state_d == COLLECT) || (state_d == FULL);
    enter_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      user_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      user_q  <= user_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      enter_q <= enter_d;
    end
  end

  assign pass_out  = pass_q;
  assign user_out  = user_q;
  assign enter_out = enter_q;
  assign digit_cnt = cnt_q;
  assign entry_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: vector table plus hand sequences for timeout, reset and backspace.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, key_enter, key_clear;
  logic [3:0]  key_code;
  logic [1:0]  user_sel;
  logic [11:0] pass_out;
  logic [1:0]  user_out;
  logic        enter_out;
  logic [1:0]  digit_cnt;
  logic        entry_err;
  logic        busy;
`ifdef KEYPAD_BACKSPACE_EN
  logic        key_back;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  keypad_entry #(.DIGITS(3), .TIMEOUT_CYCLES(10), .CNT_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
`ifdef KEYPAD_BACKSPACE_EN
    .key_back  (key_back),
`endif
    .user_sel  (user_sel),
    .pass_out  (pass_out),
    .user_out  (user_out),
    .enter_out (enter_out),
    .digit_cnt (digit_cnt),
    .entry_err (entry_err),
    .busy      (busy)
  );

  typedef struct {
    logic        v;
    logic [3:0]  c;
    logic        en;
    logic        cl;
    logic [1:0]  us;
    logic [11:0] pass;
    logic [1:0]  usr;
    logic        ent;
    logic [1:0]  cnt;
    logic        err;
    logic        bsy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic en, input logic cl,
                              input logic [1:0] us, input logic [11:0] pass, input logic [1:0] usr,
                              input logic ent, input logic [1:0] cnt, input logic err, input logic bsy);
    vec_t r;
    r.v = v; r.c = c; r.en = en; r.cl = cl; r.us = us;
    r.pass = pass; r.usr = usr; r.ent = ent; r.cnt = cnt; r.err = err; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] pass, input logic [1:0] usr,
                           input logic ent, input logic [1:0] cnt, input logic err, input logic bsy);
    chk({tag, ".pass_out"},  32'(pass_out),  32'(pass));
    chk({tag, ".user_out"},  32'(user_out),  32'(usr));
    chk({tag, ".enter_out"}, 32'(enter_out), 32'(ent));
    chk({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(cnt));
    chk({tag, ".entry_err"}, 32'(entry_err), 32'(err));
    chk({tag, ".busy"},      32'(busy),      32'(bsy));
  endtask

  // One cycle: drive at negedge, let the DUT sample, leave inputs idle just after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic en, input logic cl);
    @(negedge clk);
    key_valid = v; key_code = c; key_enter = en; key_clear = cl;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  vec_t tbl[29];

  initial begin
    tbl[0]  = mk(1, 4'h1, 0, 0, 2'd3, 12'h000, 2'd0, 0, 2'd1, 0, 1);
    tbl[1]  = mk(1, 4'h1, 0, 0, 2'd3, 12'h000, 2'd0, 0, 2'd2, 0, 1);
    tbl[2]  = mk(1, 4'h1, 0, 0, 2'd3, 12'h000, 2'd0, 0, 2'd3, 0, 1);
    tbl[3]  = mk(0, 4'h0, 1, 0, 2'd3, 12'h111, 2'd3, 1, 2'd3, 0, 0);
    tbl[4]  = mk(0, 4'h0, 0, 0, 2'd3, 12'h111, 2'd3, 0, 2'd0, 0, 0);
    tbl[5]  = mk(1, 4'hF, 0, 0, 2'd1, 12'h111, 2'd3, 0, 2'd1, 0, 1);
    tbl[6]  = mk(1, 4'h1, 0, 0, 2'd1, 12'h111, 2'd3, 0, 2'd2, 0, 1);
    tbl[7]  = mk(1, 4'hA, 0, 0, 2'd1, 12'h111, 2'd3, 0, 2'd3, 0, 1);
    tbl[8]  = mk(1, 4'h9, 0, 0, 2'd1, 12'h111, 2'd3, 0, 2'd3, 1, 1);
    tbl[9]  = mk(0, 4'h0, 1, 0, 2'd1, 12'hF1A, 2'd1, 1, 2'd3, 0, 0);
    tbl[10] = mk(0, 4'h0, 0, 0, 2'd1, 12'hF1A, 2'd1, 0, 2'd0, 0, 0);
    tbl[11] = mk(1, 4'h0, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd1, 0, 1);
    tbl[12] = mk(1, 4'hA, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd2, 0, 1);
    tbl[13] = mk(0, 4'h0, 1, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd0, 1, 0);
    tbl[14] = mk(0, 4'h0, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd0, 0, 0);
    tbl[15] = mk(1, 4'h1, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd1, 0, 1);
    tbl[16] = mk(1, 4'h2, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd2, 0, 1);
    tbl[17] = mk(1, 4'h3, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd3, 0, 1);
    tbl[18] = mk(0, 4'h0, 1, 1, 2'd0, 12'hF1A, 2'd1, 0, 2'd0, 0, 0);
    tbl[19] = mk(1, 4'h5, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd1, 0, 1);
    tbl[20] = mk(1, 4'h6, 0, 1, 2'd0, 12'hF1A, 2'd1, 0, 2'd0, 0, 0);
    tbl[21] = mk(1, 4'h5, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd1, 0, 1);
    tbl[22] = mk(1, 4'h7, 1, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd0, 1, 0);
    tbl[23] = mk(0, 4'h0, 0, 0, 2'd0, 12'hF1A, 2'd1, 0, 2'd0, 0, 0);
    tbl[24] = mk(1, 4'h3, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd1, 0, 1);
    tbl[25] = mk(1, 4'h2, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd2, 0, 1);
    tbl[26] = mk(1, 4'h1, 0, 0, 2'd2, 12'hF1A, 2'd1, 0, 2'd3, 0, 1);
    tbl[27] = mk(0, 4'h0, 1, 0, 2'd2, 12'h321, 2'd2, 1, 2'd3, 0, 0);
    tbl[28] = mk(1, 4'h7, 1, 1, 2'd0, 12'h321, 2'd2, 0, 2'd0, 0, 0);

    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0; key_clear = 1'b0;
    user_sel = 2'd0;
`ifdef KEYPAD_BACKSPACE_EN
    key_back = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 12'h000, 2'd0, 0, 2'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      user_sel = tbl[i].us;
      step(tbl[i].v, tbl[i].c, tbl[i].en, tbl[i].cl);
      check_all($sformatf("vec%0d", i), tbl[i].pass, tbl[i].usr, tbl[i].ent, tbl[i].cnt,
                tbl[i].err, tbl[i].bsy);
    end
    idle();
    check_all("post_commit", 12'h321, 2'd2, 0, 2'd0, 0, 0);

    // Timeout: a key mid-wait restarts the idle count.
    key(4'h9);
    repeat (5) idle();
    check_all("tmo_partial", 12'h321, 2'd2, 0, 2'd1, 0, 1);
    key(4'h9);
    for (int k = 1; k <= 9; k++) begin
      idle();
      chk($sformatf("tmo_wait%0d.entry_err", k), 32'(entry_err), 32'd0);
      chk($sformatf("tmo_wait%0d.busy", k), 32'(busy), 32'd1);
    end
    idle();
    check_all("tmo_fire", 12'h321, 2'd2, 0, 2'd0, 1, 0);
    idle();
    chk("tmo_after.entry_err", 32'(entry_err), 32'd0);
    user_sel = 2'd1;
    key(4'h0); key(4'h0); key(4'h1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("tmo_recommit", 12'h001, 2'd1, 1, 2'd3, 0, 0);
    idle();

    // Asynchronous reset landing in the COMMIT cycle.
    user_sel = 2'd3;
    key(4'h1); key(4'h8); key(4'h8);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("rst_commit_pre", 12'h188, 2'd3, 1, 2'd3, 0, 0);
    #2 reset = 1'b0;
    #1;
    check_all("rst_commit", 12'h000, 2'd0, 0, 2'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    check_all("rst_release", 12'h000, 2'd0, 0, 2'd0, 0, 0);

`ifdef KEYPAD_BACKSPACE_EN
    user_sel = 2'd2;
    key(4'h1); key(4'h8);
    @(negedge clk); key_back = 1'b1;
    @(posedge clk); #1; key_back = 1'b0;
    check_all("back_del", 12'h000, 2'd0, 0, 2'd1, 0, 1);
    key(4'hA); key(4'hA);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("back_commit", 12'h1AA, 2'd2, 1, 2'd3, 0, 0);
    idle();
    @(negedge clk); key_back = 1'b1;
    @(posedge clk); #1; key_back = 1'b0;
    check_all("back_idle", 12'h1AA, 2'd2, 0, 2'd0, 1, 0);
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
